// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel input synchronizer.
// The stability filter that uses sync_cnt_width() is built only with SYNC_FILT_EN.
package sync_pkg;

  localparam int SYNC_MIN_STAGES   = 32'sd2;
  localparam int SYNC_DEF_FILT_CNT = 32'sd4;

  // Counter width able to hold 0..filt_cnt.
  function automatic int sync_cnt_width(input int filt_cnt);
    return $clog2(filt_cnt + 32'sd1);
  endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// One synchronizer channel: STAGES-deep flop chain, optional stability filter
// (built when SYNC_FILT_EN is defined) and registered rise/fall pulses aligned to dout.
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter int   FILT_CNT = SYNC_DEF_FILT_CNT,
  parameter logic INIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_filt_ch: STAGES must be at least %0d", SYNC_MIN_STAGES);
  end
  if (FILT_CNT < 32'sd1) begin : g_bad_filt
    $error("sync_filt_ch: FILT_CNT must be at least 1");
  end

  (* async_reg = "true" *) logic [STAGES-1:0] sync_r;
  logic sy_s;
  logic dout_s;
  logic dout_nxt_s;
  logic rise_r;
  logic fall_r;

  // Synchronizer chain; only sync_r[0] ever sees the asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {STAGES{INIT}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
    end
  end

  assign sy_s = sync_r[STAGES-1];

`ifdef SYNC_FILT_EN
  localparam int CW = sync_cnt_width(FILT_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 32'sd1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          dout_r;

  // dout follows sy only after FILT_CNT consecutive cycles of disagreement.
  always_comb begin
    cnt_nxt_s  = {CW{1'b0}};
    dout_nxt_s = dout_r;
    if (sy_s == dout_r) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      dout_nxt_s = sy_s;
      cnt_nxt_s  = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CW'(32'd1);
    end
  end

  // Filter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= {CW{1'b0}};
      dout_r <= INIT;
    end else begin
      cnt_r  <= cnt_nxt_s;
      dout_r <= dout_nxt_s;
    end
  end

  assign dout_s = dout_r;
`else
  // Unfiltered: dout is the last chain flop, so its next value is the flop before it.
  assign dout_s     = sy_s;
  assign dout_nxt_s = sync_r[STAGES-2];
`endif

  // Edge pulses use the value dout is about to take, so they coincide with the dout change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= dout_nxt_s & ~dout_s;
      fall_r <= ~dout_nxt_s & dout_s;
    end
  end

  assign dout = dout_s;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/multi_sync_filt.sv
// WIDTH independent single-bit synchronizers with rise/fall pulses.
// Define SYNC_FILT_EN to add a FILT_CNT-cycle stability filter on every channel.
module multi_sync_filt
  import sync_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               STAGES   = 2,
  parameter int               FILT_CNT = SYNC_DEF_FILT_CNT,
  parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (WIDTH < 32'sd1) begin : g_bad_width
    $error("multi_sync_filt: WIDTH must be at least 1");
  end

  // Channels are independent: no coherency between bits of din.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filt_ch #(
      .STAGES   (STAGES),
      .FILT_CNT (FILT_CNT),
      .INIT     (INIT[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .din  (din[i]),
      .dout (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule
